// File: rtl/fc_layer_sequencer.sv
// Frame sequencer for a combinational fully-connected layer: gathers a serial
// input vector, presents it in parallel, waits for the layer to settle, then streams the results.
module fc_layer_sequencer #(
  parameter int WIDTH = 8,
  parameter int IN    = 128,
  parameter int OUT   = 10,
  parameter int ACC_W = 23,
  parameter int LAT   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic [IN*WIDTH-1:0]      vec_out,
  output logic                     vec_valid,
  input  logic [OUT*ACC_W-1:0]     res_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic [$clog2(OUT)-1:0]   out_idx,
  output logic                     out_last,
  output logic                     busy,
  output logic                     short_frame
);

  localparam int ADDR_W = (IN > 1) ? $clog2(IN) : 1;
  localparam int LEN_W  = $clog2(IN + 1);
  localparam int IDX_W  = $clog2(OUT);

  localparam logic [ADDR_W-1:0] LAST_ELEM  = ADDR_W'(IN - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(OUT - 1);
  localparam logic [3:0]        SETTLE_END = 4'(LAT - 1);

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    CAPTURE,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] cnt;
  logic [LEN_W-1:0]  len;
  logic [3:0]        settle_cnt;
  logic [IDX_W-1:0]  idx;

  logic [WIDTH-1:0]  vbuf [IN];
  logic [ACC_W-1:0]  rbuf [OUT];

  logic accept;
  logic close_frame;
  logic fire;
  logic drain_done;

  assign accept      = in_valid && in_ready;
  assign close_frame = accept && (in_last || (cnt == LAST_ELEM));
  assign fire        = out_valid && out_ready;
  assign drain_done  = fire && (idx == LAST_IDX);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    vec_valid = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && (in_last || (cnt == LAST_ELEM))) state_nxt = SETTLE;
      end
      SETTLE: begin
        vec_valid = 1'b1;
        if (settle_cnt == SETTLE_END) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        vec_valid = 1'b1;
        state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && (idx == LAST_IDX)) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      cnt         <= '0;
      len         <= LEN_W'(IN);
      settle_cnt  <= '0;
      idx         <= '0;
      short_frame <= 1'b0;
    end else begin
      state       <= state_nxt;
      short_frame <= close_frame && in_last && (cnt != LAST_ELEM);

      // cnt parks on the closing element and is cleared once the frame has drained
      if (drain_done) begin
        cnt <= '0;
        len <= LEN_W'(IN);
      end else if (close_frame) begin
        len <= LEN_W'(cnt) + LEN_W'(1);
      end else if (accept) begin
        cnt <= cnt + ADDR_W'(1);
      end

      if (state == SETTLE) begin
        settle_cnt <= (settle_cnt == SETTLE_END) ? 4'd0 : settle_cnt + 4'd1;
      end

      if (state == CAPTURE) begin
        idx <= '0;
      end else if (fire) begin
        idx <= drain_done ? '0 : idx + IDX_W'(1);
      end
    end
  end

  // Data buffers are never reset; their outputs are masked whenever not meaningful.
  always_ff @(posedge clk) begin
    if (accept) vbuf[cnt] <= in_data;
    if (state == CAPTURE) begin
      for (int j = 0; j < OUT; j++) rbuf[j] <= res_in[j*ACC_W +: ACC_W];
    end
  end

  // Elements past len read as zero, so short frames are padded without clearing the buffer.
  always_comb begin
    vec_out = '0;
    for (int i = 0; i < IN; i++) begin
      if (vec_valid && (LEN_W'(i) < len)) vec_out[i*WIDTH +: WIDTH] = vbuf[i];
    end
  end

  assign out_data = out_valid ? rbuf[idx] : '0;
  assign out_idx  = idx;
  assign out_last = out_valid && (idx == LAST_IDX);

endmodule
